// File: rtl/text_buffer.sv
// text_buffer: ROWS x COLS character memory for the text-mode display path.
// A host port does single-cell reads/writes by linear address, a display
// port reads one cell per clock, and a small FSM runs clear-screen and
// scroll-up one row per cycle. Each memory word holds one full text row;
// column c of a row lives in bits [c*CHAR_W +: CHAR_W].
module text_buffer #(
    parameter int                COLS   = 64,
    parameter int                ROWS   = 20,
    parameter int                CHAR_W = 8,
    parameter int                ADDR_W = 16,
    parameter logic [CHAR_W-1:0] BLANK  = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wen,
    input  logic                      ren,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [CHAR_W-1:0]         wdata,
    output logic [CHAR_W-1:0]         rdata,
    output logic                      rvalid,
    input  logic                      clear_req,
    input  logic                      scroll_req,
    output logic                      busy,
    output logic                      error,
    input  logic [$clog2(ROWS)-1:0]   disp_row,
    input  logic [$clog2(COLS)-1:0]   disp_col,
    output logic [CHAR_W-1:0]         disp_char
);

    localparam int ROW_W    = $clog2(ROWS);
    localparam int COL_W    = $clog2(COLS);
    localparam int CELLS    = ROWS * COLS;
    localparam int ROW_BITS = COLS * CHAR_W;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    // A full row of fill characters, used by both clear and the last scroll step
    localparam logic [ROW_BITS-1:0] BLANK_ROW = {COLS{BLANK}};

    // Storage and control state
    logic [ROW_BITS-1:0] mem_r [ROWS];
    logic [1:0]          state_r;
    logic [ROW_W-1:0]    row_ptr_r;
    logic                busy_r;
    logic [CHAR_W-1:0]   rdata_r;
    logic                rvalid_r;
    logic                error_r;
    logic [CHAR_W-1:0]   disp_char_r;

    // Decoded host access
    logic [ROW_W-1:0]    addr_row_s;
    logic [COL_W-1:0]    addr_col_s;
    logic                in_range_s;
    logic                idle_s;
    logic                cell_we_s;
    logic                cell_re_s;
    logic                err_s;
    logic [CHAR_W-1:0]   host_cell_s;

    // Row-operation datapath
    logic                row_we_s;
    logic [ROW_BITS-1:0] row_data_s;

    // Display path
    logic                disp_ok_s;
    logic [CHAR_W-1:0]   disp_cell_s;

    // Split the linear host address into row/column; true divide/modulo so
    // a non-power-of-two COLS never wraps a column into the next row.
    always_comb begin
        addr_row_s  = ROW_W'(addr / ADDR_W'(COLS));
        addr_col_s  = COL_W'(addr % ADDR_W'(COLS));
        in_range_s  = (32'(addr) < CELLS);
        host_cell_s = mem_r[addr_row_s][addr_col_s*CHAR_W +: CHAR_W];
    end

    // Host access qualification and violation detection.
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        cell_we_s = idle_s & wen & ~ren & in_range_s & ~reset;
        cell_re_s = idle_s & ren & ~wen & in_range_s;
        if (busy_r) begin
            // Anything the host asks for while an operation runs is refused
            err_s = wen | ren | clear_req | scroll_req;
        end else begin
            err_s = (wen & ren) | ((wen | ren) & ~in_range_s);
        end
    end

    // Row operation for the current FSM step: blank fill or copy-up.
    always_comb begin
        row_we_s   = 1'b0;
        row_data_s = BLANK_ROW;
        case (state_r)
            ST_CLEAR: begin
                row_we_s   = ~reset;
                row_data_s = BLANK_ROW;
            end
            ST_SCROLL: begin
                row_we_s = ~reset;
                if (row_ptr_r != LAST_ROW) begin
                    row_data_s = mem_r[row_ptr_r + ROW_ONE];
                end else begin
                    row_data_s = BLANK_ROW;
                end
            end
            default: begin
                row_we_s   = 1'b0;
                row_data_s = BLANK_ROW;
            end
        endcase
    end

    // Display lookup; out-of-range coordinates read as the fill character.
    always_comb begin
        disp_ok_s = (32'(disp_row) < ROWS) && (32'(disp_col) < COLS);
        if (disp_ok_s) begin
            disp_cell_s = mem_r[disp_row][disp_col*CHAR_W +: CHAR_W];
        end else begin
            disp_cell_s = BLANK;
        end
    end

    // Memory update: FSM row writes and host cell writes never coincide
    // because host writes are only accepted in IDLE. Contents survive reset.
    always_ff @(posedge clk) begin
        if (row_we_s) begin
            mem_r[row_ptr_r] <= row_data_s;
        end else if (cell_we_s) begin
            mem_r[addr_row_s][addr_col_s*CHAR_W +: CHAR_W] <= wdata;
        end
    end

    // Clear/scroll sequencer; reset always restarts a full clear from row 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            row_ptr_r <= ROW_ZERO;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_req) begin
                        // Clear has priority; a simultaneous scroll is dropped
                        state_r   <= ST_CLEAR;
                        row_ptr_r <= ROW_ZERO;
                        busy_r    <= 1'b1;
                    end else if (scroll_req) begin
                        state_r   <= ST_SCROLL;
                        row_ptr_r <= ROW_ZERO;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        row_ptr_r <= row_ptr_r;
                        busy_r    <= 1'b0;
                    end
                end
                ST_CLEAR, ST_SCROLL: begin
                    if (row_ptr_r == LAST_ROW) begin
                        state_r   <= ST_IDLE;
                        row_ptr_r <= ROW_ZERO;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r   <= state_r;
                        row_ptr_r <= row_ptr_r + ROW_ONE;
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    row_ptr_r <= ROW_ZERO;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Registered host read, error pulse and display character.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r     <= {CHAR_W{1'b0}};
            rvalid_r    <= 1'b0;
            error_r     <= 1'b0;
            disp_char_r <= BLANK;
        end else begin
            rvalid_r <= cell_re_s;
            if (cell_re_s) begin
                rdata_r <= host_cell_s;
            end else begin
                rdata_r <= rdata_r;
            end
            error_r     <= err_s;
            disp_char_r <= disp_cell_s;
        end
    end

    assign rdata     = rdata_r;
    assign rvalid    = rvalid_r;
    assign busy      = busy_r;
    assign error     = error_r;
    assign disp_char = disp_char_r;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: directed scenarios plus randomized
// host/display traffic, compared against a flat array model of the screen.
module tb_text_buffer;

    localparam int COLS   = 64;
    localparam int ROWS   = 20;
    localparam int CHAR_W = 8;
    localparam int ADDR_W = 16;
    localparam int CELLS  = ROWS * COLS;
    localparam logic [CHAR_W-1:0] BLANK = 8'h20;

    logic              clk;
    logic              reset;
    logic              wen;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] wdata;
    logic [CHAR_W-1:0] rdata;
    logic              rvalid;
    logic              clear_req;
    logic              scroll_req;
    logic              busy;
    logic              error;
    logic [4:0]        disp_row;
    logic [5:0]        disp_col;
    logic [CHAR_W-1:0] disp_char;

    text_buffer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CHAR_W (CHAR_W),
        .ADDR_W (ADDR_W),
        .BLANK  (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wen        (wen),
        .ren        (ren),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .clear_req  (clear_req),
        .scroll_req (scroll_req),
        .busy       (busy),
        .error      (error),
        .disp_row   (disp_row),
        .disp_col   (disp_col),
        .disp_char  (disp_char)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference screen: linear cell array, plus the last value rdata should hold
    logic [CHAR_W-1:0] model [CELLS];
    logic [CHAR_W-1:0] exp_rdata;
    int total_cnt;
    int bad_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) model[i] = BLANK;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < CELLS - COLS; i++) model[i] = model[i + COLS];
        for (int i = CELLS - COLS; i < CELLS; i++) model[i] = BLANK;
    endtask

    // One IDLE cycle of host + display traffic with full output checks.
    task automatic host_cycle(input logic w, input logic r, input int a,
                              input logic [CHAR_W-1:0] d, input int dr, input int dc);
        logic              in_rng;
        logic              exp_err;
        logic              exp_rv;
        logic [CHAR_W-1:0] exp_disp;
        in_rng  = (a >= 0) && (a < CELLS);
        exp_err = (w && r) || ((w || r) && !in_rng);
        exp_rv  = r && !w && in_rng;
        if (exp_rv) exp_rdata = model[a];
        exp_disp = (dr < ROWS && dc < COLS) ? model[dr * COLS + dc] : BLANK;
        wen      = w;
        ren      = r;
        addr     = ADDR_W'(a);
        wdata    = d;
        disp_row = 5'(dr);
        disp_col = 6'(dc);
        step();
        wen = 1'b0;
        ren = 1'b0;
        if (w && !r && in_rng) model[a] = d;
        check_val($sformatf("error a=%0d", a), error, exp_err);
        check_val($sformatf("rvalid a=%0d", a), rvalid, exp_rv);
        check_val($sformatf("rdata a=%0d", a), rdata, exp_rdata);
        check_val($sformatf("disp r=%0d c=%0d", dr, dc), disp_char, exp_disp);
        check_val("busy_idle", busy, 1'b0);
    endtask

    // Count cycles with busy high (starting at the current sample), bounded.
    task automatic wait_idle(input string tag, input int exp_cnt);
        int   cnt;
        logic err_seen;
        cnt      = 0;
        err_seen = 1'b0;
        wen = 1'b0; ren = 1'b0; clear_req = 1'b0; scroll_req = 1'b0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            err_seen = err_seen | error;
            step();
        end
        check_val({tag, "_busy_cycles"}, cnt, exp_cnt);
        check_val({tag, "_err_while_busy"}, err_seen, 1'b0);
    endtask

    // Read the whole screen through the display port and compare to the model.
    task automatic sweep();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                host_cycle(1'b0, 1'b0, 0, 8'h00, r, c);
    endtask

    task automatic random_host(input int n);
        int last_a;
        int op;
        int a;
        last_a = 0;
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 9));
            a  = int'($urandom_range(0, CELLS - 1));
            case (op)
                0, 1, 2: begin
                    host_cycle(1'b1, 1'b0, a, CHAR_W'($urandom), int'($urandom_range(0, 23)), int'($urandom_range(0, 63)));
                    last_a = a;
                end
                3: host_cycle(1'b0, 1'b1, last_a, 8'h00, int'($urandom_range(0, 23)), int'($urandom_range(0, 63)));
                4, 5: host_cycle(1'b0, 1'b1, a, 8'h00, int'($urandom_range(0, 23)), int'($urandom_range(0, 63)));
                6: host_cycle(1'b1, 1'b1, a, CHAR_W'($urandom), int'($urandom_range(0, 23)), int'($urandom_range(0, 63)));
                7: host_cycle($urandom_range(0, 1) == 1, 1'b0, int'($urandom_range(CELLS, 65535)), CHAR_W'($urandom), 0, 0);
                8: host_cycle(1'b0, 1'b1, int'($urandom_range(CELLS, 65535)), 8'h00, 0, 0);
                default: host_cycle(1'b0, 1'b0, 0, 8'h00, int'($urandom_range(0, 23)), int'($urandom_range(0, 63)));
            endcase
        end
    endtask

    initial begin
        int cmd;
        int busy_op;
        total_cnt = 0;
        bad_cnt   = 0;
        exp_rdata = 8'h00;
        reset = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = 8'h00;
        clear_req = 1'b0; scroll_req = 1'b0; disp_row = 5'd0; disp_col = 6'd0;
        model_clear();

        // Reset state and the clear that follows it
        step();
        check_val("rst_busy", busy, 1'b1);
        check_val("rst_rdata", rdata, 8'h00);
        check_val("rst_rvalid", rvalid, 1'b0);
        check_val("rst_error", error, 1'b0);
        check_val("rst_disp", disp_char, BLANK);
        reset = 1'b0;
        wait_idle("reset_clear", ROWS);
        host_cycle(1'b0, 1'b0, 0, 8'h00, 0, 0);
        host_cycle(1'b0, 1'b0, 0, 8'h00, 19, 63);
        sweep();

        // Write then immediate read-back, display of the same cell
        host_cycle(1'b1, 1'b0, 65, 8'h41, 1, 1);
        host_cycle(1'b0, 1'b1, 65, 8'h00, 1, 1);
        host_cycle(1'b0, 1'b0, 0, 8'h00, 1, 1);

        // Violations: simultaneous wen/ren, out-of-range addresses
        host_cycle(1'b1, 1'b1, 3, 8'h55, 0, 3);
        host_cycle(1'b0, 1'b1, 3, 8'h00, 0, 3);
        host_cycle(1'b1, 1'b0, CELLS, 8'h66, 0, 0);
        host_cycle(1'b0, 1'b1, CELLS, 8'h00, 0, 0);
        host_cycle(1'b1, 1'b0, 65535, 8'h67, 0, 0);
        host_cycle(1'b0, 1'b0, 0, 8'h00, 25, 10);
        sweep();

        // Scroll with a write attempted while busy
        for (int c = 0; c < COLS; c++) begin
            host_cycle(1'b1, 1'b0, COLS + c, 8'h41, 0, 0);
            host_cycle(1'b1, 1'b0, (ROWS - 1) * COLS + c, 8'h5A, 0, 0);
        end
        scroll_req = 1'b1;
        step();
        scroll_req = 1'b0;
        check_val("scroll_busy_start", busy, 1'b1);
        check_val("scroll_accept_err", error, 1'b0);
        wen = 1'b1; addr = 16'd0; wdata = 8'h77;
        step();
        wen = 1'b0;
        check_val("busy_write_err", error, 1'b1);
        check_val("busy_write_busy", busy, 1'b1);
        step();
        wait_idle("scroll", ROWS - 2);
        model_scroll();
        sweep();

        // Clear and scroll together: clear wins, no error
        random_host(40);
        clear_req  = 1'b1;
        scroll_req = 1'b1;
        step();
        clear_req  = 1'b0;
        scroll_req = 1'b0;
        wait_idle("clear_and_scroll", ROWS);
        model_clear();
        sweep();

        // Reset in the middle of a scroll restarts a full clear
        random_host(60);
        scroll_req = 1'b1;
        step();
        scroll_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rdata = 8'h00;
        check_val("midrst_busy", busy, 1'b1);
        check_val("midrst_rvalid", rvalid, 1'b0);
        check_val("midrst_rdata", rdata, 8'h00);
        check_val("midrst_error", error, 1'b0);
        wait_idle("reset_mid_scroll", ROWS);
        model_clear();
        sweep();

        // Randomized rounds: host traffic, then a command with a busy-time request
        for (int round = 0; round < 4; round++) begin
            random_host(300);
            cmd = int'($urandom_range(0, 2));
            clear_req  = (cmd != 1);
            scroll_req = (cmd != 0);
            step();
            clear_req  = 1'b0;
            scroll_req = 1'b0;
            busy_op = int'($urandom_range(0, 3));
            wen        = (busy_op == 0);
            ren        = (busy_op == 1);
            clear_req  = (busy_op == 2);
            scroll_req = (busy_op == 3);
            addr  = ADDR_W'($urandom_range(0, CELLS - 1));
            wdata = 8'hEE;
            step();
            wen = 1'b0; ren = 1'b0; clear_req = 1'b0; scroll_req = 1'b0;
            check_val($sformatf("busy_req_err op=%0d", busy_op), error, 1'b1);
            step();
            wait_idle($sformatf("rand_cmd%0d", cmd), ROWS - 2);
            if (cmd == 1) model_scroll();
            else model_clear();
            sweep();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
